// File: rtl/fp_compare_stage.sv
// Two-stage pipelined IEEE-754 compare (FEQ/FLT/FLE) with valid/ready flow control.
// Optional invalid-operation flag output enabled by defining FCMP_NV_FLAG_EN.
module fp_compare_stage #(
    parameter int BUS_WIDTH = 64,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    input  logic [TAG_WIDTH-1:0] in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0] out_rd
`ifdef FCMP_NV_FLAG_EN
    ,
    output logic                 out_nv
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a presented transaction is held until it transfers.
    localparam int EW = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int MW = BUS_WIDTH - 1 - EW;

    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    logic                 s1_valid_q, s1_valid_d;
    logic [1:0]           s1_op_q, s1_op_d;
    logic [BUS_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [BUS_WIDTH-1:0] s1_b_q, s1_b_d;
    logic [TAG_WIDTH-1:0] s1_rd_q, s1_rd_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_res_q, s2_res_d;
    logic [TAG_WIDTH-1:0] s2_rd_q, s2_rd_d;
    logic                 s2_nv_q, s2_nv_d;

    logic adv1, adv2;
    logic a_nan, b_nan, both_zero, bits_eq, a_lt_b;
    logic cmp_res, cmp_nv;
    logic [EW-1:0] a_exp, b_exp;
    logic [MW-1:0] a_man, b_man;

    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = s1_valid_q && adv2;
        in_ready = !s1_valid_q || adv2;
    end

    always_comb begin
        a_exp     = s1_a_q[BUS_WIDTH-2 -: EW];
        b_exp     = s1_b_q[BUS_WIDTH-2 -: EW];
        a_man     = s1_a_q[MW-1:0];
        b_man     = s1_b_q[MW-1:0];
        a_nan     = (&a_exp) && (|a_man);
        b_nan     = (&b_exp) && (|b_man);
        both_zero = (a_exp == '0) && (a_man == '0) && (b_exp == '0) && (b_man == '0);
        bits_eq   = (s1_a_q == s1_b_q);
        // Signed-magnitude ordering; the both-zero case is filtered out below.
        if (s1_a_q[BUS_WIDTH-1] != s1_b_q[BUS_WIDTH-1])
            a_lt_b = s1_a_q[BUS_WIDTH-1];
        else if (!s1_a_q[BUS_WIDTH-1])
            a_lt_b = s1_a_q[BUS_WIDTH-2:0] < s1_b_q[BUS_WIDTH-2:0];
        else
            a_lt_b = s1_a_q[BUS_WIDTH-2:0] > s1_b_q[BUS_WIDTH-2:0];

        cmp_res = 1'b0;
        cmp_nv  = 1'b0;
        case (s1_op_q)
            OP_FEQ: begin
                cmp_res = !(a_nan || b_nan) && (both_zero || bits_eq);
`ifdef FCMP_NV_FLAG_EN
                cmp_nv  = (a_nan && !a_man[MW-1]) || (b_nan && !b_man[MW-1]);
`endif
            end
            OP_FLT: begin
                cmp_res = !(a_nan || b_nan) && !both_zero && a_lt_b;
                cmp_nv  = a_nan || b_nan;
            end
            OP_FLE: begin
                cmp_res = !(a_nan || b_nan) && (both_zero || a_lt_b || bits_eq);
                cmp_nv  = a_nan || b_nan;
            end
            default: begin
                cmp_res = 1'b0;
                cmp_nv  = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_rd_d    = s1_rd_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_rd_d    = s2_rd_q;
        s2_nv_d    = s2_nv_q;

        // in_ready covers both an empty S1 and an S1 draining this cycle.
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d = in_op;
                s1_a_d  = in1;
                s1_b_d  = in2;
                s1_rd_d = in_rd;
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (adv1) begin
                s2_res_d = cmp_res;
                s2_rd_d  = s1_rd_q;
                s2_nv_d  = cmp_nv;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rd_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= 1'b0;
            s2_rd_q    <= '0;
            s2_nv_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_rd_q    <= s1_rd_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_rd_q    <= s2_rd_d;
            s2_nv_q    <= s2_nv_d;
        end
    end

    always_comb begin
        out_valid  = s2_valid_q;
        out_result = {{(BUS_WIDTH-1){1'b0}}, s2_res_q};
        out_rd     = s2_rd_q;
    end

`ifdef FCMP_NV_FLAG_EN
    assign out_nv = s2_nv_q;
`else
    logic unused_nv;
    assign unused_nv = s2_nv_q;
`endif

endmodule

// File: tb/tb_fp_compare_stage.sv
// Randomized scoreboard bench for fp_compare_stage; the reference model compares
// operands as IEEE doubles ($bitstoreal) rather than as bit patterns.
module tb_fp_compare_stage;
    localparam int BW = 64;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = '0;
    logic [BW-1:0] in1 = '0;
    logic [BW-1:0] in2 = '0;
    logic [TW-1:0] in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_result;
    logic [TW-1:0] out_rd;
    logic          out_nv;

    int n_cmp = 0;
    int n_fail = 0;
    logic [TW+1:0] exp_q[$];   // {result, rd, nv}
    bit rand_rdy = 0;

    fp_compare_stage #(.BUS_WIDTH(BW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in1(in1), .in2(in2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd)
`ifdef FCMP_NV_FLAG_EN
        , .out_nv(out_nv)
`endif
    );
`ifndef FCMP_NV_FLAG_EN
    assign out_nv = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [63:0] x);
        return (((x >> 52) & 64'h7FF) == 64'h7FF) && ((x & ((64'h1 << 52) - 1)) != 0);
    endfunction

    function automatic bit is_snan(input logic [63:0] x);
        return is_nan(x) && ((x & (64'h1 << 51)) == 0);
    endfunction

    // Reference: IEEE semantics via real arithmetic (NaNs handled explicitly).
    function automatic logic [TW+1:0] model(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic [TW-1:0] rd);
        bit  any_nan = is_nan(a) || is_nan(b);
        real ra = $bitstoreal(a);
        real rb = $bitstoreal(b);
        logic r = 1'b0;
        logic nv = 1'b0;
        case (op)
            2'd0: begin r = !any_nan && (ra == rb); nv = is_snan(a) || is_snan(b); end
            2'd1: begin r = !any_nan && (ra < rb);  nv = any_nan; end
            2'd2: begin r = !any_nan && (ra <= rb); nv = any_nan; end
            default: begin r = 1'b0; nv = 1'b0; end
        endcase
        return {r, rd, nv};
    endfunction

    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TW-1:0] rd);
        int waits = 0;
        bit done = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in1 = a; in2 = b; in_rd = rd;
        while (!done) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(model(op, a, b, rd));
                done = 1;
            end else if (++waits > 50) begin
                check("send_timeout", 64'd0, 64'd1);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_fp();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 11))
            0: v = 64'h0000000000000000;
            1: v = 64'h8000000000000000;
            2: v = 64'h3FF0000000000000;
            3: v = 64'hBFF0000000000000;
            4: v = 64'h7FF8000000000000 | (v & 64'h0007FFFFFFFFFFFF);
            5: v = 64'h7FF0000000000001 | (v & 64'h0003FFFFFFFFFFFF);
            6: v = 64'h7FF0000000000000 | (v & 64'h8000000000000000);
            7: v = v & 64'h800FFFFFFFFFFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // Monitor: pops on every transfer, and checks outputs stay frozen across a stall.
    bit prev_stall = 0;
    logic [BW-1:0] prev_res;
    logic [TW-1:0] prev_rd;
    logic          prev_nv;
    initial begin
        logic [TW+1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {63'd0, out_valid}, 64'd1);
                    check("hold_result", out_result, prev_res);
                    check("hold_rd", {59'd0, out_rd}, {59'd0, prev_rd});
                    check("hold_nv", {63'd0, out_nv}, {63'd0, prev_nv});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", out_result, {63'd0, e[TW+1]});
                        check("rd", {59'd0, out_rd}, {59'd0, e[TW:1]});
`ifdef FCMP_NV_FLAG_EN
                        check("nv", {63'd0, out_nv}, {63'd0, e[0]});
`endif
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_res = out_result; prev_rd = out_rd; prev_nv = out_nv;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_latency(input string tag);
        @(negedge clk); #2;
        check({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk); #2;
        check({tag, "_lat2"}, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        // Reset phase.
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_rd", {59'd0, out_rd}, 64'd0);
        check("rst_out_nv", {63'd0, out_nv}, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors from the datasheet examples.
        send(2'd0, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'd1);
        check_latency("feq_one");
        send(2'd0, 64'h0000000000000000, 64'h8000000000000000, 5'd2);
        send(2'd1, 64'h0000000000000000, 64'h8000000000000000, 5'd3);
        send(2'd2, 64'h0000000000000000, 64'h8000000000000000, 5'd4);
        send(2'd1, 64'hBFF0000000000000, 64'h4000000000000000, 5'd5);
        send(2'd1, 64'hC000000000000000, 64'hBFF0000000000000, 5'd6);
        send(2'd0, 64'h7FF8000000000000, 64'h7FF8000000000000, 5'd7);
        send(2'd0, 64'h7FF0000000000001, 64'h0000000000000000, 5'd8);
        send(2'd1, 64'h7FF8000000000000, 64'h3FF0000000000000, 5'd9);
        send(2'd3, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'd10);
        send(2'd2, 64'hFFF0000000000000, 64'h7FF0000000000000, 5'd11);

        // Eight back-to-back ops with a three-cycle stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(2'($urandom_range(0, 2)), rand_fp(), rand_fp(), 5'(16 + i));
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                @(negedge clk); #1;
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                check("stall_out_valid", {63'd0, out_valid}, 64'd1);
                @(negedge clk);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join

        // Randomized traffic with random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a, b;
            a = rand_fp();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 64'h8000000000000000;
                default: b = rand_fp();
            endcase
            send(2'($urandom_range(0, 3)), a, b, 5'($urandom));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rand_rdy = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        // Reset with both stages occupied discards everything in flight.
        out_ready = 1'b0;
        send(2'd0, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'd20);
        send(2'd1, 64'hBFF0000000000000, 64'h3FF0000000000000, 5'd21);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_result", out_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(2'd2, 64'h4000000000000000, 64'h3FF0000000000000, 5'd22);
        check_latency("post_rst");
        repeat (4) @(negedge clk);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
